// File: rtl/addsub_scheduler_pkg.sv
// Shared types and constants for the add/sub scheduler: FSM states, mode
// encoding, requester id type and the round-robin pick.
package addsub_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID_0 = 1'b0;
  localparam req_id_t REQ_ID_1 = 1'b1;

  // With both requesting, the one not served last wins; a lone request wins outright.
  function automatic req_id_t next_requester(input logic    req0,
                                             input logic    req1,
                                             input req_id_t last_id);
    req_id_t id;
    if (req0 && req1) begin
      id = ~last_id;
    end else if (req1) begin
      id = REQ_ID_1;
    end else begin
      id = REQ_ID_0;
    end
    return id;
  endfunction

endpackage

// File: rtl/addsub_slice8.sv
// Combinational 8-bit add/subtract slice; subtract is a + ~b + cin with the
// caller supplying cin = 1 on the low pass.
module addsub_slice8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovf
);

  logic [7:0] b_eff;
  logic [8:0] full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {8'd0, cin};
  assign sum   = full[7:0];
  assign cout  = full[8];
  assign ovf   = (a[7] == b_eff[7]) && (sum[7] != a[7]);

endmodule

// File: rtl/addsub_scheduler.sv
// Two-requester add/sub scheduler sharing one 8-bit slice; 16-bit operations
// take a low pass then a high pass with the carry chained through a register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request; grants and captures operands here
// ST_LO   | low byte computed through the slice, low carry registered
// ST_HI   | high byte computed with the registered low carry (16-bit)
// ST_DONE | completion registered: result/flags/done_id published
module addsub_scheduler
  import addsub_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        mode0,
  input  logic        mode1,
  input  logic        wide0,
  input  logic        wide1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done,
  output logic        done_id,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        overflow,
  output logic        busy
);

  state_t      state;
  req_id_t     last_id;
  req_id_t     cur_id;
  req_id_t     grant_id;
  logic        cur_mode;
  logic        cur_wide;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [7:0]  res_lo;
  logic [7:0]  res_hi;
  logic        carry_lo;
  logic        fin_carry;
  logic        fin_ovf;

  logic [7:0]  slice_a;
  logic [7:0]  slice_b;
  logic        slice_cin;
  logic        slice_sub;
  logic [7:0]  slice_sum;
  logic        slice_cout;
  logic        slice_ovf;

  assign grant_id = next_requester(req0, req1, last_id);

  // Slice input select: high bytes and chained carry only during ST_HI.
  assign slice_a   = (state == ST_HI) ? op_a[15:8] : op_a[7:0];
  assign slice_b   = (state == ST_HI) ? op_b[15:8] : op_b[7:0];
  assign slice_sub = (cur_mode == MODE_SUB);
  assign slice_cin = (state == ST_HI) ? carry_lo : slice_sub;

  addsub_slice8 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_cin),
    .sub  (slice_sub),
    .sum  (slice_sum),
    .cout (slice_cout),
    .ovf  (slice_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_id   <= REQ_ID_1;
      cur_id    <= REQ_ID_0;
      cur_mode  <= MODE_SUB;
      cur_wide  <= 1'b0;
      op_a      <= 16'h0000;
      op_b      <= 16'h0000;
      res_lo    <= 8'h00;
      res_hi    <= 8'h00;
      carry_lo  <= 1'b0;
      fin_carry <= 1'b0;
      fin_ovf   <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      result    <= 16'h0000;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            cur_id   <= grant_id;
            last_id  <= grant_id;
            gnt0     <= (grant_id == REQ_ID_0);
            gnt1     <= (grant_id == REQ_ID_1);
            cur_mode <= (grant_id == REQ_ID_1) ? mode1 : mode0;
            cur_wide <= (grant_id == REQ_ID_1) ? wide1 : wide0;
            op_a     <= (grant_id == REQ_ID_1) ? a1 : a0;
            op_b     <= (grant_id == REQ_ID_1) ? b1 : b0;
            state    <= ST_LO;
            busy     <= 1'b1;
          end
        end
        ST_LO: begin
          res_lo    <= slice_sum;
          carry_lo  <= slice_cout;
          fin_carry <= slice_cout;
          fin_ovf   <= slice_ovf;
          state     <= cur_wide ? ST_HI : ST_DONE;
        end
        ST_HI: begin
          res_hi    <= slice_sum;
          fin_carry <= slice_cout;
          fin_ovf   <= slice_ovf;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          done      <= 1'b1;
          done_id   <= cur_id;
          result    <= {(cur_wide ? res_hi : 8'h00), res_lo};
          carry_out <= fin_carry;
          overflow  <= fin_ovf;
          state     <= ST_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_scheduler.sv
// Directed bench for addsub_scheduler: table of single operations plus
// sequences for reset mid-operation, lone-requester start and round-robin.
module tb_addsub_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, mode0, mode1, wide0, wide1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done, done_id, carry_out, overflow, busy;
  logic [15:0] result;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        id;
    logic        mode;
    logic        wide;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[9];

  addsub_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .mode0     (mode0),
    .mode1     (mode1),
    .wide0     (wide0),
    .wide1     (wide1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done      (done),
    .done_id   (done_id),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    bit got;
    int lat;
    @(negedge clk);
    if (v.id) begin
      req1 = 1'b1; mode1 = v.mode; wide1 = v.wide; a1 = v.a; b1 = v.b;
    end else begin
      req0 = 1'b1; mode0 = v.mode; wide0 = v.wide; a0 = v.a; b0 = v.b;
    end
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (gnt0 || gnt1) got = 1;
    end
    check("op_grant_seen", got, 1);
    check("op_grant_id", {gnt1, gnt0}, v.id ? 2'b10 : 2'b01);
    check("op_busy", busy, 1);
    // Drop request and scramble operands: the in-flight op must be unaffected.
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~v.a; b0 = ~v.b; a1 = ~v.a; b1 = ~v.b;
    mode0 = ~v.mode; mode1 = ~v.mode;
    got = 0;
    lat = 0;
    for (int n = 1; n < 10 && !got; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        lat = n;
      end
    end
    check("op_done_seen", got, 1);
    check("op_latency", lat, v.wide ? 3 : 2);
    check("op_result", result, v.res);
    check("op_carry", carry_out, v.c);
    check("op_overflow", overflow, v.v);
    check("op_done_id", done_id, v.id);
    @(negedge clk);
    check("op_done_pulse", done, 0);
    check("op_result_hold", result, v.res);
  endtask

  initial begin
    bit   got;
    bit   saw_done;
    int   ng;
    int   gcyc[4];
    logic gid[4];

    vecs[0] = '{id:1'b0, mode:1'b1, wide:1'b0, a:16'h0070, b:16'h0010, res:16'h0080, c:1'b0, v:1'b1};
    vecs[1] = '{id:1'b1, mode:1'b0, wide:1'b0, a:16'h0005, b:16'h0007, res:16'h00FE, c:1'b0, v:1'b0};
    vecs[2] = '{id:1'b0, mode:1'b1, wide:1'b1, a:16'h00FF, b:16'h0001, res:16'h0100, c:1'b0, v:1'b0};
    vecs[3] = '{id:1'b1, mode:1'b0, wide:1'b1, a:16'h8000, b:16'h0001, res:16'h7FFF, c:1'b1, v:1'b1};
    vecs[4] = '{id:1'b0, mode:1'b1, wide:1'b0, a:16'h12FF, b:16'h3401, res:16'h0000, c:1'b1, v:1'b0};
    vecs[5] = '{id:1'b1, mode:1'b1, wide:1'b1, a:16'hFFFF, b:16'h0001, res:16'h0000, c:1'b1, v:1'b0};
    vecs[6] = '{id:1'b0, mode:1'b0, wide:1'b0, a:16'h0080, b:16'h0001, res:16'h007F, c:1'b1, v:1'b1};
    vecs[7] = '{id:1'b1, mode:1'b0, wide:1'b1, a:16'h1234, b:16'h1234, res:16'h0000, c:1'b1, v:1'b0};
    vecs[8] = '{id:1'b1, mode:1'b1, wide:1'b1, a:16'h7FFF, b:16'h0001, res:16'h8000, c:1'b0, v:1'b1};

    rst = 1'b1;
    req0 = 0; req1 = 0; mode0 = 0; mode1 = 0; wide0 = 0; wide1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    reset_dut();
    check("reset_outputs", {gnt0, gnt1, done, done_id, carry_out, overflow, busy}, 7'd0);
    check("reset_result", result, 16'h0000);

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Reset while the high pass of a 16-bit op is in flight.
    @(negedge clk);
    req0 = 1'b1; mode0 = 1'b1; wide0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (gnt0) got = 1;
    end
    check("rst_hi_grant", got, 1);
    @(negedge clk);
    check("rst_hi_busy", busy, 1);
    rst = 1'b1;
    req1 = 1'b1; mode1 = 1'b1; wide1 = 1'b0; a1 = 16'h0001; b1 = 16'h0001;
    #1;
    check("rst_hi_outputs", {gnt0, gnt1, done, done_id, carry_out, overflow, busy}, 7'd0);
    check("rst_hi_result", result, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    saw_done = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (gnt0 || gnt1) got = 1;
    end
    check("rst_hi_no_done", saw_done, 0);
    check("rst_hi_first_grant", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < 4; n++) @(negedge clk);

    // Lone req1 after reset, then both: requester 0 must be served next.
    reset_dut();
    req1 = 1'b1; mode1 = 1'b1; wide1 = 1'b0; a1 = 16'h0003; b1 = 16'h0004;
    @(negedge clk);
    check("lone_req1_gnt", {gnt1, gnt0}, 2'b10);
    req0 = 1'b1; mode0 = 1'b1; wide0 = 1'b0; a0 = 16'h0001; b0 = 16'h0002;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (gnt0 || gnt1) got = 1;
    end
    check("lone_next_grant", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < 4; n++) @(negedge clk);

    // Both held continuously with 8-bit ops: strict alternation every 3 cycles.
    reset_dut();
    req0 = 1'b1; req1 = 1'b1; mode0 = 1'b1; mode1 = 1'b0; wide0 = 1'b0; wide1 = 1'b0;
    ng = 0;
    for (int i = 0; i < 4; i++) begin
      gcyc[i] = 0;
      gid[i]  = 1'b0;
    end
    for (int n = 0; n < 30 && ng < 4; n++) begin
      @(negedge clk);
      check("rr_exclusive", gnt0 && gnt1, 0);
      if (gnt0 || gnt1) begin
        gid[ng]  = gnt1;
        gcyc[ng] = n;
        ng++;
      end
    end
    check("rr_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) check("rr_grant_order", gid[i], i % 2);
    for (int i = 1; i < 4; i++) check("rr_grant_spacing", gcyc[i] - gcyc[i-1], 3);
    req0 = 1'b0; req1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
